reg_bank_write_arbiter: RTL and testbench
=========================================

# reg_bank_write_arbiter

Shares the single write path of a bank of K N-bit enable registers among M requesters. Each cycle in IDLE it picks one pending request round-robin, latches its address and data, and drives exactly one register enable for one cycle. It then returns a one-cycle grant to the winner. It sits between the datapath's write sources (ALU result, load unit, immediate path, ...) and the register bank's per-register `En`/`D` inputs.

## Interface
- `N`, 8, data width of each register
- `M`, 4, number of requesters (≥2)
- `K`, 8, number of registers in the bank (≥2; need not be a power of 2)
- `AW`, derived = $clog2(K), address width (localparam)

- `Clk`  in  1  single clock, rising-edge
- `R`  in  1  reset, asynchronous, active-low
- `req`  in  M  per-requester write request, level
- `addr`  in  M*AW  requester i address in bits [i*AW +: AW]
- `data`  in  M*N  requester i data in bits [i*N +: N]
- `gnt`  out  M  one-hot, one-cycle pulse: requester's write completed
- `err`  out  1  one-cycle pulse with `gnt` when latched address ≥ K
- `reg_en`  out  K  one-hot register enable to the bank
- `reg_d`  out  N  shared data bus to every register `D`
- `busy`  out  1  high while the FSM is not in IDLE

## Operation
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If `req` ≠ 0, pick the winner as the first set bit at or after `ptr`, wrapping modulo M.
  - Latch the winner index, its `addr` and its `data`.
  - Go to WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - `reg_en[addr_q]` = 1 for this cycle only; `reg_d` = `data_q`.
  - If `addr_q` ≥ K, no `reg_en` bit is set.
  - Go to ACK.
- ACK:
  - `gnt[win_q]` = 1; `err` = (`addr_q` ≥ K).
  - `ptr` ← (`win_q` + 1) mod M.
  - Go to IDLE.
- Requester contract: hold `req`, `addr` and `data` stable until `gnt` is seen, then deassert `req` on the next cycle.
  - A `req` still high in the IDLE cycle after ACK counts as a new request, subject to round-robin order.
- A requester dropping `req` after being latched does not abort the write. WRITE and ACK still complete and `gnt` still pulses.
- Only latched values drive outputs. Input changes during WRITE/ACK have no effect.
- `reg_d` holds `data_q` in every state, and is 0 after reset until the first latch.
- All outputs are driven from flops, so they are glitch-free. This is required because the bank's `En` gates its clock.
- Reset (`R`=0, at any time including mid-operation):
  - FSM → IDLE, `ptr` = 0.
  - `gnt`, `err`, `reg_en`, `busy`, `reg_d`, `addr_q`, `data_q`, `win_q` all = 0.
  - An interrupted write is lost and no `gnt` is issued.

## Timing
- `req` sampled high in IDLE at edge t → `reg_en` high during cycle t+1 → `gnt` high during cycle t+2 → back in IDLE at t+3.
- Throughput: one write per 3 cycles. A continuously requesting single requester gets `gnt` every 3rd cycle.
- Fairness: with all M requesting continuously, each is granted once per 3*M cycles. Grant order is ptr, ptr+1, ... mod M.
- `busy` is high in WRITE and ACK, and low in IDLE.
- `reg_en` and `gnt` are never high in the same cycle.
- Reset deassertion: the first possible `reg_en` is one cycle after the first rising edge with `R`=1 and `req`≠0.

## Structure
- Package `reg_arb_pkg`: state enum `arb_state_t` {IDLE, WRITE, ACK} and helper function `rr_next(ptr, M)`.
- Sub-module `rr_picker`:
  - Combinational, parameter M.
  - Inputs `req`, `ptr`; outputs `any`, `win` index.
  - Implemented as a double-width masked priority search.
- The top holds the FSM, the `ptr`/`win_q`/`addr_q`/`data_q` flops and the output decode.

## Test plan
- Reset mid-WRITE:
  - Stimulus: M=4, K=8, N=8. `req`=0001, `addr0`=3, `data0`=8'hA5. Assert `R`=0 during the WRITE cycle.
  - Required: `reg_en` and `gnt` go 0 immediately (asynchronous), `ptr`=0, no `gnt` is ever issued, and `busy`=0.
- Single write latency:
  - Stimulus: `req`=0001, `addr0`=3, `data0`=8'hA5 at edge t.
  - Required: `reg_en`=8'b0000_1000 and `reg_d`=8'hA5 in cycle t+1, `gnt`=0001 in t+2, `busy` high in t+1..t+2 only.
- Round-robin:
  - Stimulus: `req`=1111 held, each requester drops `req` one cycle after its own `gnt` and reasserts after a further 2 cycles.
  - Required: grant order 0,1,2,3,0.
- Simultaneous requests after a pointer move:
  - Stimulus: `ptr`=2 (after granting 1), `req`=1011.
  - Required: winner 3, then 0, then 1.
- Out-of-range address:
  - Stimulus: K=6, `addr`=7.
  - Required: `reg_en`=0 during WRITE, `gnt` pulses with `err`=1 in ACK.
- Dropped request:
  - Stimulus: requester 2 latched, then `req2` dropped during WRITE.
  - Required: `reg_en` still pulses and `gnt`=0100 still issued.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  // Round-robin pointer advance: the slot after the last winner, wrapping at m.
  function automatic int rr_next(input int ptr, input int m);
    return (ptr + 1) % m;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_picker #(
  parameter int M = 4
) (
  input  logic [M-1:0]         req,
  input  logic [$clog2(M)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(M)-1:0] win
);

  localparam int PW = $clog2(M);

  logic [2*M-1:0] dbl;

  // Lower copy is masked below ptr, so a hit there is always at/after ptr;
  // the upper copy supplies the wrapped candidates.
  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < M; i++) begin
      if (i < int'(ptr)) dbl[i] = 1'b0;
    end
    any = |req;
    win = '0;
    for (int j = 2*M-1; j >= 0; j--) begin
      if (dbl[j]) win = PW'(j % M);
    end
  end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write path among M requesters.
module reg_bank_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter int K = 8
) (
  input  logic                       Clk,
  input  logic                       R,
  input  logic [M-1:0]               req,
  input  logic [M*$clog2(K)-1:0]     addr,
  input  logic [M*N-1:0]             data,
  output logic [M-1:0]               gnt,
  output logic                       err,
  output logic [K-1:0]               reg_en,
  output logic [N-1:0]               reg_d,
  output logic                       busy,
  output arb_state_t                 state,
  output logic [$clog2(M)-1:0]       ptr
);

  localparam int AW = $clog2(K);
  localparam int PW = $clog2(M);

  // Handshake: a requester holds req/addr/data until it sees its one-cycle gnt
  // pulse; the values are captured in IDLE, so later changes never matter.
  logic [PW-1:0] win, win_q;
  logic          any;
  logic [AW-1:0] sel_addr, addr_q;
  logic [N-1:0]  sel_data, data_q;
  logic [K-1:0]  en_next;
  logic [M-1:0]  win_onehot;
  logic          q_hit;

  rr_picker #(.M(M)) u_picker (
    .req (req),
    .ptr (ptr),
    .any (any),
    .win (win)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < M; i++) begin
      if (win == PW'(i)) begin
        sel_addr = addr[i*AW +: AW];
        sel_data = data[i*N +: N];
      end
    end
    en_next = '0;
    q_hit   = 1'b0;
    for (int k = 0; k < K; k++) begin
      en_next[k] = (sel_addr == AW'(k));
      if (addr_q == AW'(k)) q_hit = 1'b1;
    end
    win_onehot = '0;
    for (int i = 0; i < M; i++) begin
      win_onehot[i] = (win_q == PW'(i));
    end
  end

  // All outputs come straight from flops: the bank gates its clock with reg_en.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state  <= IDLE;
      ptr    <= '0;
      win_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      gnt    <= '0;
      err    <= 1'b0;
      reg_en <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            win_q  <= win;
            addr_q <= sel_addr;
            data_q <= sel_data;
            reg_en <= en_next;
            busy   <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          reg_en <= '0;
          gnt    <= win_onehot;
          err    <= ~q_hit;
          state  <= ACK;
        end
        ACK: begin
          gnt   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          ptr   <= PW'(rr_next(int'(win_q), M));
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign reg_d = data_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter: directed scenarios plus random traffic vs a transaction model.
module tb_reg_bank_write_arbiter;
  import reg_arb_pkg::*;

  localparam int N   = 8;
  localparam int M   = 4;
  localparam int K   = 8;
  localparam int AW  = 3;
  localparam int K6  = 6;
  localparam int AW6 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance (K=8)
  logic [M-1:0]    req;
  logic [AW-1:0]   a_arr [M];
  logic [N-1:0]    d_arr [M];
  logic [M*AW-1:0] addr;
  logic [M*N-1:0]  data;
  logic [M-1:0]    gnt;
  logic            err;
  logic [K-1:0]    reg_en;
  logic [N-1:0]    reg_d;
  logic            busy;
  arb_state_t      state;
  logic [1:0]      ptr;

  // second instance with a non-power-of-two bank (K=6)
  logic [M-1:0]     req6;
  logic [M*AW6-1:0] addr6;
  logic [M*N-1:0]   data6;
  logic [M-1:0]     gnt6;
  logic             err6;
  logic [K6-1:0]    reg_en6;
  logic [N-1:0]     reg_d6;
  logic             busy6;
  arb_state_t       state6;
  logic [1:0]       ptr6;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      addr[i*AW +: AW] = a_arr[i];
      data[i*N +: N]   = d_arr[i];
    end
  end

  reg_bank_write_arbiter #(.N(N), .M(M), .K(K)) dut (
    .Clk(clk), .R(rst_n), .req(req), .addr(addr), .data(data),
    .gnt(gnt), .err(err), .reg_en(reg_en), .reg_d(reg_d), .busy(busy),
    .state(state), .ptr(ptr)
  );

  reg_bank_write_arbiter #(.N(N), .M(M), .K(K6)) dut6 (
    .Clk(clk), .R(rst_n), .req(req6), .addr(addr6), .data(data6),
    .gnt(gnt6), .err(err6), .reg_en(reg_en6), .reg_d(reg_d6), .busy(busy6),
    .state(state6), .ptr(ptr6)
  );

  int checks = 0;
  int errors = 0;

  // transaction-level model of the main instance
  int            m_ptr, m_left, m_win;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  m_data;
  logic [K-1:0]  exp_en;
  logic [N-1:0]  exp_d;
  logic [M-1:0]  exp_gnt;
  logic          exp_err, exp_busy;

  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  task automatic model_reset();
    m_ptr = 0; m_left = 0; m_win = 0; m_addr = '0; m_data = '0;
    exp_en = '0; exp_d = '0; exp_gnt = '0; exp_err = 1'b0; exp_busy = 1'b0;
  endtask

  // Advance one clock; the model sees the same req/addr/data the DUT samples.
  task automatic tick();
    logic [M-1:0] r;
    int w;
    r = req;
    @(posedge clk);
    exp_en = '0; exp_gnt = '0; exp_err = 1'b0;
    if (m_left == 0) begin
      if (r != '0) begin
        w = -1;
        for (int k = 0; k < M; k++) begin
          if (w < 0 && r[(m_ptr + k) % M]) w = (m_ptr + k) % M;
        end
        m_win = w; m_addr = a_arr[w]; m_data = d_arr[w];
        if (int'(m_addr) < K) exp_en = K'(1) << m_addr;
        exp_busy = 1'b1;
        m_left = 2;
      end else begin
        exp_busy = 1'b0;
      end
    end else if (m_left == 2) begin
      exp_gnt = M'(1) << m_win;
      exp_err = (int'(m_addr) >= K);
      exp_busy = 1'b1;
      m_left = 1;
    end else begin
      m_ptr = (m_win + 1) % M;
      exp_busy = 1'b0;
      m_left = 0;
    end
    exp_d = m_data;
    #1;
  endtask

  function automatic int idx_of(logic [M-1:0] g);
    for (int i = 0; i < M; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; req6 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; req6 = '0;
    #2;
    checks++;
    if ({reg_en, reg_d, gnt, err, busy} !== '0 || state !== IDLE || ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset: en=%h d=%h gnt=%b err=%b busy=%b st=%0d ptr=%0d, want all 0",
               reg_en, reg_d, gnt, err, busy, state, ptr);
    end
    checks++;
    if ({reg_en6, reg_d6, gnt6, err6, busy6} !== '0) begin
      errors++;
      $display("FAIL reset_k6: en=%h d=%h gnt=%b err=%b busy=%b, want all 0",
               reg_en6, reg_d6, gnt6, err6, busy6);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    a_arr[0] = 3'd3; d_arr[0] = 8'hA5; req = 4'b0001;
    tick();
    checks++;
    if (reg_en !== 8'h08 || reg_d !== 8'hA5 || busy !== 1'b1 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL single_t1: en=%h d=%h busy=%b gnt=%b, want en=08 d=a5 busy=1 gnt=0000",
               reg_en, reg_d, busy, gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || reg_en !== 8'h00 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_t2: gnt=%b busy=%b en=%h err=%b, want gnt=0001 busy=1 en=00 err=0",
               gnt, busy, reg_en, err);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0 || reg_d !== 8'hA5) begin
      errors++;
      $display("FAIL single_t3: busy=%b gnt=%b d=%h, want busy=0 gnt=0000 d=a5", busy, gnt, reg_d);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    a_arr[0] = 3'd3; d_arr[0] = 8'hA5; req = 4'b0001;
    tick();
    checks++;
    if (reg_en !== 8'h08 || state !== WRITE) begin
      errors++;
      $display("FAIL midrst_write: en=%h st=%0d, want en=08 st=WRITE", reg_en, state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (reg_en !== '0 || gnt !== '0 || busy !== 1'b0 || ptr !== 2'd0 || reg_d !== '0 || state !== IDLE) begin
      errors++;
      $display("FAIL midrst_async: en=%h gnt=%b busy=%b ptr=%0d d=%h st=%0d, want all 0",
               reg_en, gnt, busy, ptr, reg_d, state);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (gnt !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_nognt cyc%0d: gnt=%b busy=%b, want 0000/0", c, gnt, busy);
      end
    end
  endtask

  task automatic test_round_robin();
    int off [M];
    do_reset();
    for (int i = 0; i < M; i++) begin
      a_arr[i] = AW'(i + 2); d_arr[i] = N'(8'h10 * (i + 1)); off[i] = 0;
    end
    req = 4'b1111;
    got_q.delete();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int c = 0; c < 60 && got_q.size() < 5; c++) begin
      tick();
      checks++;
      if ({reg_en, reg_d, gnt, err, busy} !== {exp_en, exp_d, exp_gnt, exp_err, exp_busy}) begin
        errors++;
        $display("FAIL rr_model cyc%0d: en=%h d=%h gnt=%b err=%b busy=%b want en=%h d=%h gnt=%b err=%b busy=%b",
                 c, reg_en, reg_d, gnt, err, busy, exp_en, exp_d, exp_gnt, exp_err, exp_busy);
      end
      for (int i = 0; i < M; i++) begin
        if (off[i] > 0) begin
          off[i]--;
          if (off[i] == 0) req[i] = 1'b1;
        end
      end
      if (gnt != '0) begin
        got_q.push_back(2'(idx_of(gnt)));
        req[idx_of(gnt)] = 1'b0;
        off[idx_of(gnt)] = 3;
      end
    end
    req = '0;
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, want 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, want %0d", i, got_q[i], exp_q[i]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_ptr_move();
    do_reset();
    for (int i = 0; i < M; i++) begin
      a_arr[i] = AW'(7 - i); d_arr[i] = N'(8'hC0 + i);
    end
    req = 4'b0010;
    for (int c = 0; c < 10 && gnt == '0; c++) tick();
    req = 4'b1011;
    got_q.delete();
    exp_q = '{2'd3, 2'd0, 2'd1};
    tick();
    checks++;
    if (ptr !== 2'd2) begin
      errors++;
      $display("FAIL ptr_move_ptr: got %0d, want 2", ptr);
    end
    if (gnt != '0) got_q.push_back(2'(idx_of(gnt)));
    for (int c = 0; c < 30 && got_q.size() < 3; c++) begin
      tick();
      checks++;
      if ({reg_en, reg_d, gnt, err, busy} !== {exp_en, exp_d, exp_gnt, exp_err, exp_busy}) begin
        errors++;
        $display("FAIL ptr_move_model cyc%0d: en=%h d=%h gnt=%b busy=%b want en=%h d=%h gnt=%b busy=%b",
                 c, reg_en, reg_d, gnt, busy, exp_en, exp_d, exp_gnt, exp_busy);
      end
      if (gnt != '0) begin
        got_q.push_back(2'(idx_of(gnt)));
        req[idx_of(gnt)] = 1'b0;
      end
    end
    req = '0;
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL ptr_move_count: got %0d grants, want 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ptr_move_order[%0d]: got %0d, want %0d", i, got_q[i], exp_q[i]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_dropped_request();
    do_reset();
    a_arr[2] = 3'd6; d_arr[2] = 8'h5A; req = 4'b0100;
    tick();
    req = 4'b0000;
    checks++;
    if (reg_en !== 8'h40 || reg_d !== 8'h5A) begin
      errors++;
      $display("FAIL dropped_en: en=%h d=%h, want en=40 d=5a", reg_en, reg_d);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dropped_gnt: gnt=%b busy=%b, want 0100/1", gnt, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL dropped_idle: busy=%b gnt=%b, want 0/0000", busy, gnt);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    addr6 = '0; data6 = '0;
    addr6[0 +: AW6] = 3'd7; data6[0 +: N] = 8'h3C; req6 = 4'b0001;
    tick();
    checks++;
    if (reg_en6 !== '0 || busy6 !== 1'b1 || reg_d6 !== 8'h3C) begin
      errors++;
      $display("FAIL oor_write: en=%b busy=%b d=%h, want en=000000 busy=1 d=3c", reg_en6, busy6, reg_d6);
    end
    tick();
    checks++;
    if (gnt6 !== 4'b0001 || err6 !== 1'b1 || reg_en6 !== '0) begin
      errors++;
      $display("FAIL oor_ack: gnt=%b err=%b en=%b, want gnt=0001 err=1 en=000000", gnt6, err6, reg_en6);
    end
    req6 = '0;
    tick();
    checks++;
    if (err6 !== 1'b0 || busy6 !== 1'b0) begin
      errors++;
      $display("FAIL oor_idle: err=%b busy=%b, want 0/0", err6, busy6);
    end
    addr6[2*AW6 +: AW6] = 3'd5; data6[2*N +: N] = 8'h77; req6 = 4'b0100;
    tick();
    checks++;
    if (reg_en6 !== 6'b100000 || reg_d6 !== 8'h77) begin
      errors++;
      $display("FAIL k6_top_write: en=%b d=%h, want en=100000 d=77", reg_en6, reg_d6);
    end
    tick();
    checks++;
    if (gnt6 !== 4'b0100 || err6 !== 1'b0) begin
      errors++;
      $display("FAIL k6_top_ack: gnt=%b err=%b, want 0100/0", gnt6, err6);
    end
    req6 = '0;
    tick();
  endtask

  task automatic test_random();
    int grants [M];
    do_reset();
    for (int i = 0; i < M; i++) grants[i] = 0;
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom_range(0, 15));
      for (int i = 0; i < M; i++) begin
        a_arr[i] = 3'($urandom_range(0, 7));
        d_arr[i] = 8'($urandom_range(0, 255));
      end
      tick();
      checks++;
      if ({reg_en, reg_d, gnt, err, busy} !== {exp_en, exp_d, exp_gnt, exp_err, exp_busy}) begin
        errors++;
        $display("FAIL random cyc%0d: en=%h d=%h gnt=%b err=%b busy=%b want en=%h d=%h gnt=%b err=%b busy=%b",
                 c, reg_en, reg_d, gnt, err, busy, exp_en, exp_d, exp_gnt, exp_err, exp_busy);
      end
      if (gnt != '0) grants[idx_of(gnt)]++;
    end
    req = '0;
    for (int i = 0; i < M; i++) begin
      checks++;
      if (grants[i] == 0) begin
        errors++;
        $display("FAIL random_starved: requester %0d got 0 grants, want >0", i);
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    req = '0; req6 = '0; addr6 = '0; data6 = '0;
    for (int i = 0; i < M; i++) begin
      a_arr[i] = '0; d_arr[i] = '0;
    end
    model_reset();
    test_reset();
    test_single_write();
    test_reset_mid_write();
    test_round_robin();
    test_ptr_move();
    test_dropped_request();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
